// File: rtl/comms_ctrl_param.sv
// Packet controller between rx UART, event router, register map and FIFO/tx path.
// Decodes rx packets, runs local regmap accesses, forwards traffic and queues router events.
module comms_ctrl_param #(
    parameter int unsigned WIDTH        = 64,
    parameter logic [7:0]  GLOBAL_ID    = 8'd255,
    parameter logic [31:0] MAGIC_NUMBER = 32'h8950_4E47,
    parameter int unsigned READ_LATENCY = 2,
    parameter int unsigned TIMEOUT      = 15,
    parameter int unsigned CNT_W        = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-2:0] rx_data,
    input  logic             rx_data_flag,
    input  logic [WIDTH-2:0] pre_event,
    input  logic             load_event,
    input  logic [7:0]       chip_id,
    input  logic [7:0]       regmap_read_data,
    input  logic             tx_busy,
    output logic [WIDTH-2:0] output_event,
    output logic             write_fifo_n,
    output logic             fifo_ack,
    output logic [7:0]       regmap_address,
    output logic [7:0]       regmap_write_data,
    output logic             write_regmap,
    output logic             read_regmap,
    output logic             send_config_data,
    output logic             comms_busy,
    output logic [CNT_W-1:0] bad_packets,
    output logic [CNT_W-1:0] total_packets,
    output logic [CNT_W-1:0] pass_packets
);
    localparam int unsigned W = WIDTH - 1;
    localparam logic [W-1:0] REPLY_FLAG = (W > 62) ? (W'(1) << 62) : '0;
    localparam logic [1:0] OP_INV = 2'b00;
    localparam logic [1:0] OP_WR  = 2'b10;
    localparam logic [1:0] OP_RD  = 2'b11;

    typedef enum logic [3:0] {
        S_READY, S_CFG_WRITE, S_CFG_READ, S_CFG_REPLY, S_PASS_CFG, S_TX_WAIT,
        S_TX_SEND, S_PASS_ALONG, S_LOAD_EVENT, S_WRITE_FIFO, S_BAD_PACKET, S_WAIT
    } state_t;

    state_t           r_state;
    logic [W-1:0]     r_rx_data, r_pre_event, r_pkt, r_output_event;
    logic             r_rx_flag, r_load, r_bcast, r_fwd_pending;
    logic [2:0]       r_lat_cnt;
    logic [7:0]       r_wait_cnt, r_addr, r_wdata;
    logic             r_write_fifo_n, r_fifo_ack, r_write_regmap, r_read_regmap;
    logic             r_send, r_comms_busy;
    logic [CNT_W-1:0] r_bad, r_total, r_pass;

    logic [1:0]  w_op;
    logic [7:0]  w_id;
    logic        w_bcast, w_match, w_magic_ok;

    assign w_op       = r_rx_data[1:0];
    assign w_id       = r_rx_data[9:2];
    assign w_bcast    = (w_id == GLOBAL_ID);
    assign w_match    = (w_id == chip_id) || w_bcast;
    assign w_magic_ok = (r_rx_data[57:26] == MAGIC_NUMBER);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // Outputs are registered from the next state, so each strobe spans exactly its state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state        <= S_READY;
            r_rx_data      <= '0;
            r_rx_flag      <= 1'b0;
            r_pre_event    <= '0;
            r_load         <= 1'b0;
            r_pkt          <= '0;
            r_bcast        <= 1'b0;
            r_fwd_pending  <= 1'b0;
            r_lat_cnt      <= '0;
            r_wait_cnt     <= '0;
            r_output_event <= '0;
            r_addr         <= '0;
            r_wdata        <= '0;
            r_write_fifo_n <= 1'b1;
            r_fifo_ack     <= 1'b0;
            r_write_regmap <= 1'b0;
            r_read_regmap  <= 1'b0;
            r_send         <= 1'b0;
            r_comms_busy   <= 1'b0;
            r_bad          <= '0;
            r_total        <= '0;
            r_pass         <= '0;
        end else begin
            r_rx_data      <= rx_data;
            r_rx_flag      <= rx_data_flag;
            r_pre_event    <= pre_event;
            r_load         <= load_event;
            r_write_fifo_n <= 1'b1;
            r_fifo_ack     <= 1'b0;
            r_write_regmap <= 1'b0;
            r_read_regmap  <= 1'b0;
            r_send         <= 1'b0;
            r_comms_busy   <= 1'b1;
            case (r_state)
                S_READY: begin
                    if (r_rx_flag) begin
                        r_pkt         <= r_rx_data;
                        r_bcast       <= w_bcast;
                        r_fwd_pending <= 1'b0;
                        if (w_op == OP_INV || (w_op[1] && !w_magic_ok)) begin
                            r_state <= S_BAD_PACKET;
                            r_bad   <= sat_inc(r_bad);
                        end else if (w_op == OP_WR && w_match) begin
                            r_state        <= S_CFG_WRITE;
                            r_write_regmap <= 1'b1;
                            r_addr         <= r_rx_data[17:10];
                            r_wdata        <= r_rx_data[25:18];
                        end else if (w_op == OP_RD && w_match) begin
                            r_state       <= S_CFG_READ;
                            r_read_regmap <= 1'b1;
                            r_addr        <= r_rx_data[17:10];
                            r_lat_cnt     <= '0;
                            r_fwd_pending <= w_bcast;
                        end else if (w_op[1]) begin
                            r_state        <= S_PASS_CFG;
                            r_output_event <= r_rx_data;
                            r_pass         <= sat_inc(r_pass);
                        end else begin
                            r_state        <= S_PASS_ALONG;
                            r_output_event <= r_rx_data;
                            r_pass         <= sat_inc(r_pass);
                        end
                    end else if (r_load) begin
                        r_state        <= S_LOAD_EVENT;
                        r_output_event <= r_pre_event;
                        r_total        <= sat_inc(r_total);
                    end else begin
                        r_comms_busy <= 1'b0;
                    end
                end
                S_CFG_WRITE: begin
                    if (r_bcast) begin
                        r_state        <= S_PASS_CFG;
                        r_output_event <= r_pkt;
                        r_pass         <= sat_inc(r_pass);
                    end else begin
                        r_state    <= S_WAIT;
                        r_wait_cnt <= '0;
                    end
                end
                S_CFG_READ: begin
                    if (r_lat_cnt == 3'(READ_LATENCY - 1)) begin
                        r_state        <= S_CFG_REPLY;
                        r_output_event <= {r_pkt[W-1:26], regmap_read_data, r_pkt[17:10],
                                           chip_id, r_pkt[1:0]} | REPLY_FLAG;
                        r_total        <= sat_inc(r_total);
                    end else begin
                        r_read_regmap <= 1'b1;
                        r_lat_cnt     <= r_lat_cnt + 3'd1;
                    end
                end
                S_CFG_REPLY:  r_state <= S_TX_WAIT;
                S_PASS_CFG:   r_state <= S_TX_WAIT;
                S_TX_WAIT: begin
                    if (!tx_busy) begin
                        r_state <= S_TX_SEND;
                        r_send  <= 1'b1;
                    end
                end
                // A broadcast read replies first, then forwards the original packet.
                S_TX_SEND: begin
                    if (r_fwd_pending) begin
                        r_state        <= S_PASS_CFG;
                        r_fwd_pending  <= 1'b0;
                        r_output_event <= r_pkt;
                        r_pass         <= sat_inc(r_pass);
                    end else begin
                        r_state    <= S_WAIT;
                        r_wait_cnt <= '0;
                    end
                end
                S_PASS_ALONG: begin
                    r_state        <= S_WRITE_FIFO;
                    r_write_fifo_n <= 1'b0;
                end
                S_LOAD_EVENT: begin
                    r_state        <= S_WRITE_FIFO;
                    r_write_fifo_n <= 1'b0;
                    r_fifo_ack     <= 1'b1;
                end
                S_WRITE_FIFO, S_BAD_PACKET: begin
                    r_state    <= S_WAIT;
                    r_wait_cnt <= '0;
                end
                S_WAIT: begin
                    if (!r_rx_flag || r_wait_cnt == 8'(TIMEOUT - 1)) begin
                        r_state      <= S_READY;
                        r_comms_busy <= 1'b0;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 8'd1;
                    end
                end
                default: begin
                    r_state      <= S_READY;
                    r_comms_busy <= 1'b0;
                end
            endcase
        end
    end

    assign output_event      = r_output_event;
    assign write_fifo_n      = r_write_fifo_n;
    assign fifo_ack          = r_fifo_ack;
    assign regmap_address    = r_addr;
    assign regmap_write_data = r_wdata;
    assign write_regmap      = r_write_regmap;
    assign read_regmap       = r_read_regmap;
    assign send_config_data  = r_send;
    assign comms_busy        = r_comms_busy;
    assign bad_packets       = r_bad;
    assign total_packets     = r_total;
    assign pass_packets      = r_pass;
endmodule

// File: tb/tb_comms_ctrl_param.sv
// Scoreboard bench for comms_ctrl_param: expected regmap writes, tx launches and
// FIFO writes are queued with the stimulus and popped as the DUT produces them.
module tb_comms_ctrl_param;
    localparam logic [31:0] MAGIC = 32'h8950_4E47;
    localparam logic [1:0]  K_WR = 2'd0, K_TX = 2'd1, K_FIFO = 2'd2;

    typedef struct packed {
        logic [1:0]  kind;
        logic [62:0] word;
        logic        ack;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [62:0] rx_data = '0;
    logic        rx_data_flag = 1'b0;
    logic [62:0] pre_event = '0;
    logic        load_event = 1'b0;
    logic [7:0]  chip_id = 8'h05;
    logic [7:0]  regmap_read_data = '0;
    logic        tx_busy = 1'b0;
    logic [62:0] output_event;
    logic        write_fifo_n, fifo_ack, write_regmap, read_regmap, send_config_data, comms_busy;
    logic [7:0]  regmap_address, regmap_write_data;
    logic [7:0]  bad_packets, total_packets, pass_packets;

    int   checks = 0;
    int   failures = 0;
    exp_t exp_q[$];
    exp_t obs, exp_e;

    comms_ctrl_param #(
        .WIDTH(64), .GLOBAL_ID(8'd255), .MAGIC_NUMBER(MAGIC),
        .READ_LATENCY(3), .TIMEOUT(4), .CNT_W(8)
    ) dut (
        .clk(clk), .reset_n(reset_n), .rx_data(rx_data), .rx_data_flag(rx_data_flag),
        .pre_event(pre_event), .load_event(load_event), .chip_id(chip_id),
        .regmap_read_data(regmap_read_data), .tx_busy(tx_busy), .output_event(output_event),
        .write_fifo_n(write_fifo_n), .fifo_ack(fifo_ack), .regmap_address(regmap_address),
        .regmap_write_data(regmap_write_data), .write_regmap(write_regmap),
        .read_regmap(read_regmap), .send_config_data(send_config_data),
        .comms_busy(comms_busy), .bad_packets(bad_packets), .total_packets(total_packets),
        .pass_packets(pass_packets)
    );

    always #5 clk = ~clk;

    function automatic logic [62:0] mk_pkt(input logic [1:0] op, input logic [7:0] id,
                                           input logic [7:0] addr, input logic [7:0] data,
                                           input logic [31:0] magic);
        return {5'b0, magic, data, addr, id, op};
    endfunction

    function automatic exp_t mk_exp(input logic [1:0] kind, input logic [62:0] word,
                                    input logic ack);
        exp_t e;
        e.kind = kind;
        e.word = word;
        e.ack  = ack;
        return e;
    endfunction

    // Output monitor: every strobe pops the oldest expectation.
    always @(negedge clk) begin
        if (reset_n) begin
            if (send_config_data) begin
                checks++;
                if (tx_busy !== 1'b0) begin
                    failures++;
                    $display("FAIL send_while_busy tx_busy=%b required=0", tx_busy);
                end
            end
            if (write_regmap || send_config_data || !write_fifo_n) begin
                obs.kind = write_regmap ? K_WR : (send_config_data ? K_TX : K_FIFO);
                obs.word = write_regmap ? {47'b0, regmap_address, regmap_write_data} : output_event;
                obs.ack  = fifo_ack;
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL sb_unexpected kind=%0d word=%h ack=%b required none",
                             obs.kind, obs.word, obs.ack);
                end else begin
                    exp_e = exp_q.pop_front();
                    if (obs !== exp_e) begin
                        failures++;
                        $display("FAIL sb_event kind=%0d word=%h ack=%b required kind=%0d word=%h ack=%b",
                                 obs.kind, obs.word, obs.ack, exp_e.kind, exp_e.word, exp_e.ack);
                    end
                end
            end
        end
    end

    task automatic send_pkt(input logic [62:0] pkt);
        bit seen, done;
        seen = 0; done = 0;
        rx_data = pkt;
        rx_data_flag = 1'b1;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if (comms_busy) begin seen = 1; rx_data_flag = 1'b0; end
            else if (seen) done = 1;
        end
        checks++;
        if (!done) begin failures++; $display("FAIL pkt_done done=%0d required=1", done); end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({write_fifo_n, fifo_ack, write_regmap, read_regmap, send_config_data, comms_busy} !== 6'b100000) begin
            failures++;
            $display("FAIL reset_strobes got=%b required=100000",
                     {write_fifo_n, fifo_ack, write_regmap, read_regmap, send_config_data, comms_busy});
        end
        checks++;
        if ({output_event, regmap_address, regmap_write_data} !== '0) begin
            failures++;
            $display("FAIL reset_data ev=%h addr=%h data=%h required 0", output_event, regmap_address, regmap_write_data);
        end
        checks++;
        if ({bad_packets, total_packets, pass_packets} !== 24'h0) begin
            failures++;
            $display("FAIL reset_counters got=%h required=000000", {bad_packets, total_packets, pass_packets});
        end
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_cfg_write();
        bit seen, done;
        seen = 0; done = 0;
        exp_q.push_back(mk_exp(K_WR, 63'({8'h10, 8'hA5}), 1'b0));
        rx_data = mk_pkt(2'b10, 8'h05, 8'h10, 8'hA5, MAGIC);
        rx_data_flag = 1'b1;
        @(negedge clk);
        checks++;
        if (write_regmap !== 1'b0) begin failures++; $display("FAIL wr_early got=%b required=0", write_regmap); end
        @(negedge clk);
        checks++;
        if (write_regmap !== 1'b1) begin failures++; $display("FAIL wr_latency got=%b required=1", write_regmap); end
        for (int i = 0; i < 40 && !done; i++) begin
            if (comms_busy) begin seen = 1; rx_data_flag = 1'b0; end
            else if (seen) done = 1;
            if (!done) @(negedge clk);
        end
        checks++;
        if (!done) begin failures++; $display("FAIL wr_done done=%0d required=1", done); end
        checks++;
        if ({bad_packets, total_packets, pass_packets} !== 24'h0) begin
            failures++;
            $display("FAIL wr_counters got=%h required=000000", {bad_packets, total_packets, pass_packets});
        end
    endtask

    task automatic test_bcast_read();
        bit seen, done;
        int rd_cnt;
        logic [62:0] orig;
        seen = 0; done = 0; rd_cnt = 0;
        orig = mk_pkt(2'b11, 8'hFF, 8'h22, 8'h77, MAGIC);
        exp_q.push_back(mk_exp(K_TX, {1'b1, 4'b0, MAGIC, 8'h3C, 8'h22, 8'h05, 2'b11}, 1'b0));
        exp_q.push_back(mk_exp(K_TX, orig, 1'b0));
        tx_busy = 1'b1;
        regmap_read_data = 8'hEE;
        rx_data = orig;
        rx_data_flag = 1'b1;
        for (int i = 0; i < 80 && !done; i++) begin
            @(negedge clk);
            if (read_regmap) begin
                rd_cnt++;
                regmap_read_data = (rd_cnt == 3) ? 8'h3C : 8'hEE;
            end
            if (i == 11) tx_busy = 1'b0;
            if (comms_busy) begin seen = 1; rx_data_flag = 1'b0; end
            else if (seen) done = 1;
        end
        checks++;
        if (!done) begin failures++; $display("FAIL rd_done done=%0d required=1", done); end
        checks++;
        if (rd_cnt != 3) begin failures++; $display("FAIL rd_cycles got=%0d required=3", rd_cnt); end
        checks++;
        if (exp_q.size() != 0) begin failures++; $display("FAIL rd_pending got=%0d required=0", exp_q.size()); end
        checks++;
        if ({total_packets, pass_packets} !== 16'h0101) begin
            failures++;
            $display("FAIL rd_counters got=%h required=0101", {total_packets, pass_packets});
        end
    endtask

    task automatic test_bad_packets();
        send_pkt(mk_pkt(2'b10, 8'h05, 8'h10, 8'h11, 32'h0));
        checks++;
        if (bad_packets !== 8'd1) begin failures++; $display("FAIL bad_magic got=%0d required=1", bad_packets); end
        send_pkt(mk_pkt(2'b00, 8'h05, 8'h10, 8'h11, MAGIC));
        checks++;
        if (bad_packets !== 8'd2) begin failures++; $display("FAIL bad_op got=%0d required=2", bad_packets); end
        checks++;
        if ({total_packets, pass_packets} !== 16'h0101) begin
            failures++;
            $display("FAIL bad_other_counters got=%h required=0101", {total_packets, pass_packets});
        end
    endtask

    task automatic test_back_to_back();
        bit done;
        logic [62:0] pkt;
        done = 0;
        pkt = mk_pkt(2'b01, 8'h33, 8'h44, 8'h55, 32'hDEAD_BEEF);
        exp_q.push_back(mk_exp(K_FIFO, pkt, 1'b0));
        exp_q.push_back(mk_exp(K_FIFO, 63'h1234_5678_9ABC_DEF0, 1'b1));
        rx_data = pkt;
        rx_data_flag = 1'b1;
        pre_event = 63'h1234_5678_9ABC_DEF0;
        load_event = 1'b1;
        for (int i = 0; i < 60 && !done; i++) begin
            @(negedge clk);
            if (comms_busy) rx_data_flag = 1'b0;
            if (fifo_ack) load_event = 1'b0;
            if (!load_event && !rx_data_flag && !comms_busy) done = 1;
        end
        checks++;
        if (!done) begin failures++; $display("FAIL b2b_done done=%0d required=1", done); end
        checks++;
        if (exp_q.size() != 0) begin failures++; $display("FAIL b2b_pending got=%0d required=0", exp_q.size()); end
        checks++;
        if ({total_packets, pass_packets} !== 16'h0202) begin
            failures++;
            $display("FAIL b2b_counters got=%h required=0202", {total_packets, pass_packets});
        end
    endtask

    task automatic test_timeout();
        bit seen, done;
        int busy_cnt;
        seen = 0; done = 0; busy_cnt = 0;
        rx_data = mk_pkt(2'b00, 8'h05, 8'h00, 8'h00, MAGIC);
        rx_data_flag = 1'b1;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if (comms_busy) busy_cnt++;
            else if (busy_cnt > 0) done = 1;
        end
        checks++;
        if (busy_cnt != 5 || !done) begin
            failures++;
            $display("FAIL timeout_busy got=%0d done=%0d required=5 done=1", busy_cnt, done);
        end
        rx_data_flag = 1'b0;
        done = 0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if (comms_busy) seen = 1;
            else if (seen) done = 1;
        end
        checks++;
        if (bad_packets !== 8'd4 || !done) begin
            failures++;
            $display("FAIL timeout_bad got=%0d done=%0d required=4 done=1", bad_packets, done);
        end
    endtask

    task automatic test_saturation();
        bit done;
        int exp_total;
        exp_total = 2;
        for (int n = 0; n < 260; n++) begin
            done = 0;
            pre_event = 63'({$urandom(), $urandom()});
            exp_q.push_back(mk_exp(K_FIFO, pre_event, 1'b1));
            load_event = 1'b1;
            for (int i = 0; i < 20 && !done; i++) begin
                @(negedge clk);
                if (fifo_ack) load_event = 1'b0;
                if (!load_event && !comms_busy) done = 1;
            end
            exp_total = (exp_total == 255) ? 255 : exp_total + 1;
            checks++;
            if (!done || total_packets !== 8'(exp_total)) begin
                failures++;
                $display("FAIL sat_total n=%0d got=%0d done=%0d required=%0d", n, total_packets, done, exp_total);
            end
        end
        checks++;
        if (exp_q.size() != 0) begin failures++; $display("FAIL sat_pending got=%0d required=0", exp_q.size()); end
    endtask

    task automatic test_reset_mid_read();
        bit hit;
        hit = 0;
        rx_data = mk_pkt(2'b11, 8'h05, 8'h66, 8'h00, MAGIC);
        rx_data_flag = 1'b1;
        for (int i = 0; i < 10 && !hit; i++) begin
            @(negedge clk);
            if (read_regmap) hit = 1;
        end
        checks++;
        if (!hit) begin failures++; $display("FAIL mid_read_start got=%0d required=1", hit); end
        reset_n = 1'b0;
        #1;
        checks++;
        if ({write_fifo_n, fifo_ack, write_regmap, read_regmap, send_config_data, comms_busy} !== 6'b100000) begin
            failures++;
            $display("FAIL mid_reset_strobes got=%b required=100000",
                     {write_fifo_n, fifo_ack, write_regmap, read_regmap, send_config_data, comms_busy});
        end
        checks++;
        if ({output_event, regmap_address, regmap_write_data} !== '0) begin
            failures++;
            $display("FAIL mid_reset_data ev=%h addr=%h data=%h required 0", output_event, regmap_address, regmap_write_data);
        end
        checks++;
        if ({bad_packets, total_packets, pass_packets} !== 24'h0) begin
            failures++;
            $display("FAIL mid_reset_counters got=%h required=000000", {bad_packets, total_packets, pass_packets});
        end
        rx_data_flag = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (8) @(negedge clk);
        checks++;
        if (comms_busy !== 1'b0 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL mid_reset_idle busy=%b pending=%0d required busy=0 pending=0", comms_busy, exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_cfg_write();
        test_bcast_read();
        test_bad_packets();
        test_back_to_back();
        test_timeout();
        test_saturation();
        test_reset_mid_read();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
